xm_mod_mac: RTL and testbench

- Parametrised successor to the fixed 48-bit multiply-by-modulus unit used in the Montgomery reduction datapath.
- Computes r = acc + q*MOD, or r = q*MOD when acc is disabled, for a compile-time modulus of any width.
- Splits MOD into a low and a high slice to form two narrower partial products.
- Fully pipelined with valid/ready handshakes on both sides, so it sits between the quotient-digit generator and the reduction accumulator and tolerates back-pressure.

---
 rtl/xm_pkg.sv | 18 +
 rtl/xm_pipe_stage.sv | 35 +++
 rtl/xm_mod_mac.sv | 85 ++++++++
 tb/tb_xm_mod_mac.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xm_pkg.sv
// Shared constants and elaboration helpers for the modular multiply-accumulate datapath.
package xm_pkg;

    localparam int unsigned Q_W_DEF   = 48;
    localparam int unsigned MOD_W_DEF = 256;
    localparam int unsigned SPLIT_DEF = 128;

    // Current prime in sparse form: p = 2^C1 - C0
    localparam int unsigned P25519_C1 = 255;
    localparam int unsigned P25519_C0 = 19;
    localparam logic [255:0] MOD_P25519 = (256'd1 << P25519_C1) - 256'(P25519_C0);

    // Split point must leave at least one bit in each modulus slice
    function automatic bit mod_split_ok(input int unsigned split, input int unsigned mod_w);
        return (split >= 1) && (split < mod_w);
    endfunction

endpackage

// File: rtl/xm_pipe_stage.sv
// Generic valid/ready register slice; an empty slot always accepts, so bubbles collapse.
module xm_pipe_stage #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready_c,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    assign o_ready_c = !r_valid || i_ready;
    assign o_valid   = r_valid;
    assign o_data    = r_data;

    // Advance when the slot is empty or its contents are being taken; otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready_c) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/xm_mod_mac.sv
// Two-stage pipelined r = acc + q*MOD using split low/high modulus partial products.
module xm_mod_mac
    import xm_pkg::*;
#(
    parameter int unsigned       Q_W   = Q_W_DEF,
    parameter int unsigned       MOD_W = MOD_W_DEF,
    parameter logic [MOD_W-1:0]  MOD   = MOD_W'(MOD_P25519),
    parameter int unsigned       SPLIT = SPLIT_DEF,
    localparam int unsigned      ACC_W = Q_W + MOD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q_W-1:0]   in_q,
    input  logic [ACC_W-1:0] in_acc,
    input  logic             in_acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W:0]   out_r,
    output logic             busy
);

    localparam int unsigned LO_W  = Q_W + SPLIT;
    localparam int unsigned HI_W  = Q_W + MOD_W - SPLIT;
    localparam int unsigned S1_W  = HI_W + LO_W + ACC_W;
    localparam int unsigned RES_W = ACC_W + 1;

    localparam logic [SPLIT-1:0]       MOD_LO = MOD[SPLIT-1:0];
    localparam logic [MOD_W-SPLIT-1:0] MOD_HI = MOD[MOD_W-1:SPLIT];

    // Reject split points that would leave an empty modulus slice
    if (!mod_split_ok(SPLIT, MOD_W)) begin : g_bad_split
        $error("xm_mod_mac: SPLIT must lie in 1..MOD_W-1");
    end

    logic [LO_W-1:0]  w_pp_lo;
    logic [HI_W-1:0]  w_pp_hi;
    logic [ACC_W-1:0] w_acc_m;
    logic [S1_W-1:0]  w_s1_in;
    logic [S1_W-1:0]  w_s1_out;
    logic             w_s1_valid;
    logic             w_s2_ready_c;
    logic [LO_W-1:0]  w_s1_pp_lo;
    logic [HI_W-1:0]  w_s1_pp_hi;
    logic [ACC_W-1:0] w_s1_acc;
    logic [RES_W-1:0] w_sum;

    // Partial products against the two constant modulus slices
    assign w_pp_lo = LO_W'(in_q) * LO_W'(MOD_LO);
    assign w_pp_hi = HI_W'(in_q) * HI_W'(MOD_HI);
    assign w_acc_m = in_acc_en ? in_acc : '0;
    assign w_s1_in = {w_pp_hi, w_pp_lo, w_acc_m};

    xm_pipe_stage #(.DATA_W(S1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (in_valid),
        .o_ready_c (in_ready),
        .i_data    (w_s1_in),
        .o_valid   (w_s1_valid),
        .i_ready   (w_s2_ready_c),
        .o_data    (w_s1_out)
    );

    // Recombine at full width so the carry into the top bit survives
    assign w_s1_pp_hi = w_s1_out[S1_W-1 -: HI_W];
    assign w_s1_pp_lo = w_s1_out[ACC_W +: LO_W];
    assign w_s1_acc   = w_s1_out[ACC_W-1:0];
    assign w_sum      = RES_W'(w_s1_acc) + (RES_W'(w_s1_pp_hi) << SPLIT) + RES_W'(w_s1_pp_lo);

    xm_pipe_stage #(.DATA_W(RES_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (w_s1_valid),
        .o_ready_c (w_s2_ready_c),
        .i_data    (w_sum),
        .o_valid   (out_valid),
        .i_ready   (out_ready),
        .o_data    (out_r)
    );

    assign busy = w_s1_valid || out_valid;

endmodule

// File: tb/tb_xm_mod_mac.sv
// Directed and random checks of xm_mod_mac against a direct big-integer model.
module tb_xm_mod_mac;

    localparam int unsigned Q_W   = 48;
    localparam int unsigned ACC_W = 304;
    localparam int unsigned RES_W = 305;
    localparam int unsigned N_RAND = 10000;
    localparam logic [255:0] MOD =
        256'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFED;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [Q_W-1:0]   in_q;
    logic [ACC_W-1:0] in_acc;
    logic             in_acc_en;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_r;
    logic             busy;

    int n_assert = 0;
    int n_fail   = 0;
    logic [RES_W-1:0] sb_q[$];

    logic             prev_stall = 1'b0;
    logic [RES_W-1:0] prev_r = '0;

    always #5 clk = ~clk;

    xm_mod_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_acc    (in_acc),
        .in_acc_en (in_acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .busy      (busy)
    );

    function automatic logic [RES_W-1:0] model(input logic [Q_W-1:0] q,
                                               input logic [ACC_W-1:0] acc,
                                               input logic en);
        logic [RES_W-1:0] a;
        a = en ? RES_W'(acc) : '0;
        return a + RES_W'(q) * RES_W'(MOD);
    endfunction

    task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat was accepted
    task automatic send(input logic [Q_W-1:0] q, input logic [ACC_W-1:0] acc, input logic en);
        int k;
        in_valid  = 1'b1;
        in_q      = q;
        in_acc    = acc;
        in_acc_en = en;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("send_timeout", RES_W'(in_ready), RES_W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_idle", RES_W'(busy), RES_W'(0));
        chk("drain_sb_empty", RES_W'(sb_q.size()), RES_W'(0));
    endtask

    // Scoreboard monitor: handshakes sampled mid-cycle reflect the next rising edge
    always @(negedge clk) begin
        logic [RES_W-1:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", RES_W'(out_valid), RES_W'(1));
                chk("stall_data_held", out_r, prev_r);
            end
            if (in_valid && in_ready) sb_q.push_back(model(in_q, in_acc, in_acc_en));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", RES_W'(out_valid), RES_W'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("result", out_r, e);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_r     = out_r;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic took;
        int   n_sent;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_q      = '0;
        in_acc    = '0;
        in_acc_en = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", RES_W'(out_valid), RES_W'(0));
        chk("rst_busy", RES_W'(busy), RES_W'(0));
        chk("rst_out_r", out_r, RES_W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", RES_W'(in_ready), RES_W'(1));

        // q=1, acc disabled: MOD after exactly two cycles
        send(48'd1, '0, 1'b0);
        @(negedge clk);
        chk("lat_cycle1_no_valid", RES_W'(out_valid), RES_W'(0));
        chk("lat_cycle1_busy", RES_W'(busy), RES_W'(1));
        @(negedge clk);
        chk("lat_cycle2_valid", RES_W'(out_valid), RES_W'(1));
        chk("q1_is_mod", out_r, RES_W'(MOD));
        @(posedge clk);
        #1;
        drain();

        // acc passthrough, then acc ignored when disabled
        send(48'd0, 304'd5, 1'b1);
        send(48'd3, 304'd1, 1'b0);
        send(48'd7, {ACC_W{1'b1}}, 1'b0);
        drain();

        // Maximum operands: carry lands in the top bit
        send({Q_W{1'b1}}, {ACC_W{1'b1}}, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("max_valid", RES_W'(out_valid), RES_W'(1));
        chk("max_top_bit", RES_W'(out_r[ACC_W]), RES_W'(1));
        @(posedge clk);
        #1;
        drain();

        // Back-pressure: two accepts then in_ready drops while output is stalled
        out_ready = 1'b0;
        send(48'd1, '0, 1'b0);
        send(48'd2, '0, 1'b0);
        in_valid = 1'b1;
        in_q     = 48'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", RES_W'(in_ready), RES_W'(0));
            chk("bp_out_r_held", out_r, RES_W'(MOD));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_out1", RES_W'(out_valid), RES_W'(1));
        chk("bp_rel_accept3", RES_W'(in_ready), RES_W'(1));
        @(posedge clk);
        #1;
        in_q = 48'd4;
        @(negedge clk);
        chk("bp_rel_out2", RES_W'(out_valid), RES_W'(1));
        chk("bp_rel_accept4", RES_W'(in_ready), RES_W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_rel_out3", RES_W'(out_valid), RES_W'(1));
        @(negedge clk);
        chk("bp_rel_out4", RES_W'(out_valid), RES_W'(1));
        @(negedge clk);
        chk("bp_rel_done", RES_W'(out_valid), RES_W'(0));
        @(posedge clk);
        #1;
        drain();

        // Reset with two beats in flight discards both
        send(48'd5, '0, 1'b0);
        send(48'd6, '0, 1'b0);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("midrst_out_valid", RES_W'(out_valid), RES_W'(0));
        chk("midrst_busy", RES_W'(busy), RES_W'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_no_valid", RES_W'(out_valid), RES_W'(0));
            chk("postrst_idle", RES_W'(busy), RES_W'(0));
        end
        @(posedge clk);
        #1;

        // Random traffic with 50% valid and ready density
        n_sent = 0;
        for (int cyc = 0; cyc < 60000 && n_sent < int'(N_RAND); cyc++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) n_sent++;
            if (!in_valid || took) begin
                in_valid  = (n_sent < int'(N_RAND)) && ($urandom_range(1, 0) == 1);
                in_q      = ($urandom_range(15, 0) == 0) ? {Q_W{1'b1}} : Q_W'({$urandom, $urandom});
                in_acc    = ACC_W'({$urandom, $urandom, $urandom, $urandom, $urandom,
                                    $urandom, $urandom, $urandom, $urandom, $urandom});
                in_acc_en = ($urandom_range(1, 0) == 1);
            end
            out_ready = ($urandom_range(1, 0) == 1);
        end
        in_valid = 1'b0;
        chk("rand_all_sent", RES_W'(n_sent), RES_W'(N_RAND));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
